add_sequencer: RTL and testbench



---
 rtl/add_seq_pkg.sv | 11 +
 rtl/add_seq_chunk_adder.sv | 16 +
 rtl/add_sequencer.sv | 126 ++++++++++++
 tb/tb_add_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and default widths for the chunk-serial adder (add_sequencer).
package add_seq_pkg;
  localparam int DATA_W_DEF  = 64;
  localparam int CHUNK_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/add_seq_chunk_adder.sv
// Combinational CHUNK_W-bit adder with carry in/out; the one shared datapath slice.
module add_seq_chunk_adder #(
  parameter int CHUNK_W = 16
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);
  logic [CHUNK_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
  assign sum  = full[CHUNK_W-1:0];
  assign cout = full[CHUNK_W];
endmodule

// File: rtl/add_sequencer.sv
// Multi-cycle DATA_W adder: one CHUNK_W adder walked LSB chunk first with a carry register.
// Define ADD_SEQ_SUB_EN to add the in_sub port (a - b via inverted b and forced carry-in).
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic              busy
);
  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

  generate
    if (DATA_W % CHUNK_W != 0) begin : g_bad_width
      $error("add_sequencer: DATA_W must be a multiple of CHUNK_W");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [CHUNK_W-1:0] ch_a, ch_b, ch_sum;
  logic               ch_cout;
  logic               load_sub;

  assign ch_a = a_q[cnt_q*CHUNK_W +: CHUNK_W];
  assign ch_b = b_q[cnt_q*CHUNK_W +: CHUNK_W];

  add_seq_chunk_adder #(.CHUNK_W(CHUNK_W)) u_chunk_adder (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

`ifdef ADD_SEQ_SUB_EN
  assign load_sub = in_sub;
`else
  assign load_sub = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          // Subtract is a + ~b + 1, so only the load differs from an add.
          b_d     = load_sub ? ~in_b : in_b;
          carry_d = load_sub ? 1'b1 : in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q*CHUNK_W +: CHUNK_W] = ch_sum;
        carry_d = ch_cout;
        if (cnt_q == CNT_LAST) begin
          cout_d  = ch_cout;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
endmodule

// File: tb/tb_add_sequencer.sv
// Directed bench for add_sequencer at default widths (64/16, 4 chunks).
module tb_add_sequencer;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  add_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADD_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Present one op, wait for out_valid (bounded); lat counts edges after accept.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
`ifdef ADD_SEQ_SUB_EN
    in_sub = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy got %b/%b want 0/0", out_valid, busy); end
    checks++; if (out_sum !== '0 || out_cout !== 1'b0) begin errors++; $display("FAIL reset_sum got %h/%b want 0/0", out_sum, out_cout); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== '0)
        begin errors++; $display("FAIL idle_hold cyc %0d rdy=%b vld=%b busy=%b sum=%h want 1/0/0/0", i, in_ready, out_valid, busy, out_sum); end
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_flags got rdy=%b busy=%b want 0/1", in_ready, busy); end
    wait_done(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL latency got %0d want 4", lat); end
    checks++; if (out_sum !== 64'h0 || out_cout !== 1'b1) begin errors++; $display("FAIL carry_chain got %h/%b want 0/1", out_sum, out_cout); end
    retire();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL retire got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 1'b0);
    wait_done(lat);
    checks++; if (out_sum !== 64'h0000_0000_0001_0001 || out_cout !== 1'b0) begin errors++; $display("FAIL cin_op got %h/%b want 0000000000010001/0", out_sum, out_cout); end
    retire();
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", lat); end
    checks++; if (out_sum !== 64'h0 || out_cout !== 1'b1) begin errors++; $display("FAIL msb_op got %h/%b want 0/1", out_sum, out_cout); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    wait_done(lat);
    in_valid = 1'b1; in_a = 64'hDEAD; in_b = 64'hBEEF; in_cin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 64'h1234_5678_9ABC_DF00 || out_cout !== 1'b0)
        begin errors++; $display("FAIL hold cyc %0d vld=%b rdy=%b sum=%h/%b want 1/0/123456789abcdf00/0", i, out_valid, in_ready, out_sum, out_cout); end
    end
    in_valid = 1'b0;
    retire();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b busy=%b want 1/0", in_ready, busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    int lat;
    start_op(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_cout !== 1'b0)
      begin errors++; $display("FAIL async_reset busy=%b vld=%b rdy=%b sum=%h cout=%b want 0/0/1/0/0", busy, out_valid, in_ready, out_sum, out_cout); end
    @(negedge clk); rst_n = 1'b1;
    start_op(64'd3, 64'd4, 1'b0, 1'b0);
    wait_done(lat);
    checks++; if (lat != 4 || out_sum !== 64'd7 || out_cout !== 1'b0) begin errors++; $display("FAIL post_reset got lat=%0d sum=%h/%b want 4/7/0", lat, out_sum, out_cout); end
    retire();
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_sub();
    int lat;
    start_op(64'd5, 64'd7, 1'b0, 1'b1);
    wait_done(lat);
    checks++; if (out_sum !== 64'hFFFF_FFFF_FFFF_FFFE || out_cout !== 1'b0) begin errors++; $display("FAIL sub_borrow got %h/%b want fffffffffffffffe/0", out_sum, out_cout); end
    retire();
    start_op(64'd7, 64'd5, 1'b0, 1'b1);
    wait_done(lat);
    checks++; if (out_sum !== 64'd2 || out_cout !== 1'b1) begin errors++; $display("FAIL sub_noborrow got %h/%b want 2/1", out_sum, out_cout); end
    retire();
    in_sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
`ifdef ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
